// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// CLK runs at the bit rate; TX_OUT and Busy are registered from next-state logic.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        START = 3'b001,
        DATA  = 3'b011,
        PAR   = 3'b010,
        STOP  = 3'b110
    } state_t;

    state_t                r_state,   w_state_nxt;
    logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift,   w_shift_nxt;
    logic                  r_par_en,  w_par_en_nxt;
    logic                  r_par_bit, w_par_bit_nxt;
    logic                  r_tx,      w_tx_nxt;
    logic                  r_busy,    w_busy_nxt;
    logic                  w_accept;

    assign w_accept = DATA_VALID && ((r_state == IDLE) || (r_state == STOP));

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_tx_nxt      = 1'b1;

        // Parity is folded into one bit at accept time so PAR_TYP need not be kept.
        if (w_accept) begin
            w_state_nxt   = START;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = P_DATA;
            w_par_en_nxt  = PAR_EN;
            w_par_bit_nxt = (^P_DATA) ^ PAR_TYP;
            w_tx_nxt      = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                START: begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                end
                DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        if (r_par_en) begin
                            w_state_nxt = PAR;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = STOP;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                    end
                end
                PAR: begin
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames, back-to-back, mid-frame noise,
// mid-frame reset and randomized frames against a per-period bit-list model.
module tb_uart_tx_frame;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         TX_OUT;
    logic         Busy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic exp_q[$];

    uart_tx_frame #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Line level for every bit period of one frame, from the frame rules.
    task automatic model_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        int ones;
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
        if (pe) begin
            ones = $countones(d);
            if (pt == 1'b0) exp_q.push_back((ones % 2) == 1);
            else            exp_q.push_back((ones % 2) == 0);
        end
        exp_q.push_back(1'b1);
    endtask

    // Called at the negedge just after the accept edge; returns at the negedge
    // of the last checked period (the stop period when n_chk < 0).
    task automatic check_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                               input int glitch, input int n_chk, input string name);
        int lim;
        model_frame(d, pe, pt);
        lim = (n_chk >= 0) ? n_chk : exp_q.size();
        for (int j = 0; j < lim; j++) begin
            if (j > 0) @(negedge CLK);
            chk($sformatf("%s tx[%0d]", name, j), TX_OUT, exp_q[j]);
            chk($sformatf("%s busy[%0d]", name, j), Busy, 1'b1);
            if (j == glitch) begin
                DATA_VALID = 1'b1;
                P_DATA     = W'($urandom);
                PAR_TYP    = ~PAR_TYP;
                PAR_EN     = ~PAR_EN;
            end else if (j == glitch + 1) begin
                DATA_VALID = 1'b0;
            end
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            chk($sformatf("%s idle tx", name), TX_OUT, 1'b1);
            chk($sformatf("%s idle busy", name), Busy, 1'b0);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt,
                        input int glitch, input string name);
        DATA_VALID = 1'b1;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        check_frame(d, pe, pt, glitch, -1, name);
        check_idle(name, 1);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] dn;
        logic         pe, pt, pen, ptn;
        int           nfr, gl;

        RST        = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("reset tx", TX_OUT, 1'b1);
        chk("reset busy", Busy, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        check_idle("post_reset", 3);

        send(8'hA5, 1'b0, 1'b0, -10, "a5_nopar");
        send(8'hA5, 1'b1, 1'b0, -10, "a5_even");
        send(8'hA5, 1'b1, 1'b1, -10, "a5_odd");
        send(8'h01, 1'b1, 1'b0, -10, "01_even");
        send(8'hFF, 1'b1, 1'b1, -10, "ff_odd");
        check_idle("gap", 2);

        // Back-to-back with DATA_VALID held; P_DATA changes in the first stop period.
        DATA_VALID = 1'b1;
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        @(negedge CLK);
        check_frame(8'h55, 1'b0, 1'b0, -10, -1, "b2b_55");
        P_DATA = 8'h0F;
        @(negedge CLK);
        check_frame(8'h0F, 1'b0, 1'b0, -10, -1, "b2b_0f");
        DATA_VALID = 1'b0;
        check_idle("b2b", 2);

        // Noise on DATA_VALID / P_DATA / parity controls during the data bits.
        send(8'h3C, 1'b1, 1'b0, 3, "noise_par");
        send(8'hC3, 1'b0, 1'b1, 2, "noise_nopar");
        check_idle("noise", 2);

        // Reset during data bit 3 (period index 4).
        DATA_VALID = 1'b1;
        P_DATA     = 8'h96;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        check_frame(8'h96, 1'b1, 1'b0, -10, 5, "rst_mid");
        #2 RST = 1'b0;
        #1;
        chk("rst_mid async tx", TX_OUT, 1'b1);
        chk("rst_mid async busy", Busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        check_idle("rst_release", 4);
        send(8'h6B, 1'b1, 1'b1, -10, "after_rst");

        // Randomized single frames and back-to-back chains.
        for (int it = 0; it < 40; it++) begin
            d  = W'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W - 1)) : -10;
                send(d, pe, pt, gl, $sformatf("rnd%0d", it));
            end else begin
                nfr        = $urandom_range(2, 3);
                DATA_VALID = 1'b1;
                P_DATA     = d;
                PAR_EN     = pe;
                PAR_TYP    = pt;
                @(negedge CLK);
                for (int f = 0; f < nfr; f++) begin
                    check_frame(d, pe, pt, -10, -1, $sformatf("chain%0d_%0d", it, f));
                    if (f < nfr - 1) begin
                        dn  = W'($urandom);
                        pen = 1'($urandom);
                        ptn = 1'($urandom);
                        P_DATA  = dn;
                        PAR_EN  = pen;
                        PAR_TYP = ptn;
                        d  = dn;
                        pe = pen;
                        pt = ptn;
                        @(negedge CLK);
                    end else begin
                        DATA_VALID = 1'b0;
                    end
                end
                check_idle($sformatf("chain%0d", it), 1);
            end
            if ($urandom_range(0, 3) == 0) check_idle($sformatf("rndgap%0d", it), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
